// File: rtl/square_pkg.sv
// square_pkg: scan-mode encodings, FSM state and the skip-mode priority find for square_scan
package square_pkg;
  localparam logic SCAN_ALL  = 1'b0;
  localparam logic SCAN_SKIP = 1'b1;
  typedef enum logic {IDLE, ITERATE} state_e;
  // returns {found, index} of the lowest set bit of vec strictly above idx; idx=-1 finds the lowest set bit
  function automatic logic [5:0] next_valid(input logic [31:0] vec, input int idx);
    logic [5:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--)
      if (vec[i] && i > idx) r = {1'b1, 5'(i)};
    return r;
  endfunction
endpackage

// File: rtl/square_stack_fifo.sv
// square_stack_fifo: register-array show-ahead FIFO with count, full/empty and synchronous active-low clear
module square_stack_fifo #(
  parameter int DEPTH  = 16,
  parameter int MOVE_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_i,
  input  logic [MOVE_W-1:0]            wdata_i,
  input  logic                         rd_i,
  output logic [MOVE_W-1:0]            rdata_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   num_o,
  output logic                         drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [MOVE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] num_q;
  logic do_wr, do_rd;
  assign empty_o = num_q == '0;
  assign full_o  = num_q == CW'(DEPTH);
  assign do_rd   = rd_i && !empty_o;
  // a read frees the slot at the same edge, so a write into a full FIFO is accepted when paired with a read
  assign do_wr   = wr_i && (!full_o || rd_i);
  assign drop_o  = wr_i && full_o && !rd_i;
  assign rdata_o = empty_o ? '0 : mem_q[rp_q];
  assign num_o   = num_q;
  always_ff @(posedge clk)
    if (do_wr) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk)
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      num_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(do_wr);
      rp_q  <= rp_q + AW'(do_rd);
      num_q <= num_q + CW'(do_wr) - CW'(do_rd);
    end
endmodule

// File: rtl/square_scan.sv
// square_scan: scans neighbour move lanes one per cycle and pushes valid moves into a show-ahead FIFO
module square_scan
  import square_pkg::*;
#(
  parameter int   NDIR      = 16,
  parameter int   MOVE_W    = 16,
  parameter int   DEPTH     = 16,
  parameter logic SCAN_MODE = SCAN_ALL
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        collect_pieces,
  input  logic [NDIR-1:0]             rx_valid,
  input  logic [NDIR*MOVE_W-1:0]      rx_moves,
  input  logic                        stack_read,
  output logic [MOVE_W-1:0]           stack_arbiter,
  output logic                        stack_empty,
  output logic                        stack_full,
  output logic [$clog2(DEPTH+1)-1:0]  stack_num,
  output logic                        overflow,
  output logic                        scan_done,
  output logic [$clog2(NDIR)-1:0]     direction_idx
);
  localparam int IW = $clog2(NDIR);
  state_e state_q;
  logic [IW-1:0] idx_q, idx_d, start_idx;
  logic done_q, ovf_q, lane_valid, last, more, wr, drop, unused_ok;
  logic [MOVE_W-1:0] lane_move;
  logic [5:0] first, nxt;
  assign first      = next_valid(32'(rx_valid), -1);
  assign nxt        = next_valid(32'(rx_valid), int'(idx_q));
  assign unused_ok  = ^{first, nxt};
  assign lane_valid = rx_valid[idx_q];
  assign lane_move  = rx_moves[idx_q*MOVE_W +: MOVE_W];
  assign start_idx  = SCAN_MODE == SCAN_SKIP ? first[IW-1:0] : '0;
  assign last       = SCAN_MODE == SCAN_SKIP ? !nxt[5] : idx_q == IW'(NDIR - 1);
  assign idx_d      = last ? start_idx : SCAN_MODE == SCAN_SKIP ? nxt[IW-1:0] : idx_q + 1'b1;
  // a pass can only start when there is at least one lane to visit
  assign more       = collect_pieces && (SCAN_MODE == SCAN_ALL || first[5]);
  assign wr         = state_q == ITERATE && lane_valid;
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (state_q == IDLE) begin
      done_q <= collect_pieces && !more;
      if (more) begin
        state_q <= ITERATE;
        idx_q   <= start_idx;
        ovf_q   <= 1'b0;
      end
    end else begin
      done_q <= last;
      idx_q  <= idx_d;
      ovf_q  <= ovf_q || drop;
      if (last && !more) state_q <= IDLE;
    end
  square_stack_fifo #(.DEPTH(DEPTH), .MOVE_W(MOVE_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_i    (wr),
    .wdata_i (lane_move),
    .rd_i    (stack_read),
    .rdata_o (stack_arbiter),
    .empty_o (stack_empty),
    .full_o  (stack_full),
    .num_o   (stack_num),
    .drop_o  (drop)
  );
  assign overflow      = ovf_q;
  assign scan_done     = done_q;
  assign direction_idx = idx_q;
endmodule

// File: tb/tb_square_scan.sv
// tb_square_scan: table, directed and randomized checks of a scan-all (depth 4) and a scan-skip square_scan
module tb_square_scan;
  import square_pkg::*;
  typedef struct {logic coll; logic rd; logic [3:0] idx; logic done; logic [4:0] num; logic [15:0] head;} vec_t;
  logic clk = 1'b0, rst = 1'b0;
  logic coll_a = 1'b0, coll_s = 1'b0, rd_a = 1'b0, rd_s = 1'b0;
  logic [15:0] valid = '0;
  logic [255:0] moves = '0;
  logic [15:0] a_arb, s_arb;
  logic a_emp, s_emp, a_full, s_full, a_ovf, s_ovf, a_done, s_done;
  logic [2:0] a_num;
  logic [4:0] s_num;
  logic [3:0] a_idx, s_idx;
  int depth [2] = '{4, 16};
  logic [15:0] fq [2][16];
  int cnt [2], nl [2], pos [2], idle_idx [2], lanes [2][16];
  bit ovf [2], done [2];
  int n_pass = 0, n_chk = 0;
  vec_t tv [8];
  always #5 clk = ~clk;
  square_scan #(.NDIR(16), .MOVE_W(16), .DEPTH(4), .SCAN_MODE(SCAN_ALL)) dut_a (
    .clk(clk), .rst(rst), .collect_pieces(coll_a), .rx_valid(valid), .rx_moves(moves),
    .stack_read(rd_a), .stack_arbiter(a_arb), .stack_empty(a_emp), .stack_full(a_full),
    .stack_num(a_num), .overflow(a_ovf), .scan_done(a_done), .direction_idx(a_idx));
  square_scan #(.NDIR(16), .MOVE_W(16), .DEPTH(16), .SCAN_MODE(SCAN_SKIP)) dut_s (
    .clk(clk), .rst(rst), .collect_pieces(coll_s), .rx_valid(valid), .rx_moves(moves),
    .stack_read(rd_s), .stack_arbiter(s_arb), .stack_empty(s_emp), .stack_full(s_full),
    .stack_num(s_num), .overflow(s_ovf), .scan_done(s_done), .direction_idx(s_idx));
  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
  endtask
  task automatic pop(input int d);
    for (int i = 0; i < 15; i++) fq[d][i] = fq[d][i+1];
    cnt[d]--;
  endtask
  task automatic push(input int d, input logic [15:0] v);
    fq[d][cnt[d]] = v;
    cnt[d]++;
  endtask
  // the lanes a pass visits: every lane for scan-all, the set valid bits for scan-skip
  task automatic fill(input int d);
    pos[d] = 0;
    nl[d] = 0;
    for (int i = 0; i < 16; i++)
      if (d == 0 || valid[i]) begin
        lanes[d][nl[d]] = i;
        nl[d]++;
      end
  endtask
  task automatic model(input int d, input logic coll, input logic rd);
    bit inp;
    int l;
    done[d] = 0;
    if (!rst) begin
      cnt[d] = 0; ovf[d] = 0; nl[d] = 0; pos[d] = 0; idle_idx[d] = 0;
      return;
    end
    inp = pos[d] < nl[d];
    if (rd && cnt[d] > 0) pop(d);
    if (inp) begin
      l = lanes[d][pos[d]];
      if (valid[l]) begin
        if (cnt[d] < depth[d]) push(d, moves[l*16 +: 16]);
        else ovf[d] = 1;
      end
      pos[d]++;
      if (pos[d] == nl[d]) begin
        done[d] = 1;
        fill(d);
        idle_idx[d] = nl[d] > 0 ? lanes[d][0] : 0;
        if (!coll || nl[d] == 0) begin
          nl[d] = 0;
          pos[d] = 0;
        end
      end
    end else if (coll) begin
      fill(d);
      if (nl[d] == 0) done[d] = 1;
      else ovf[d] = 0;
    end
  endtask
  task automatic chk_dut(input int d, input logic [15:0] arb, input logic emp, input logic full,
                         input logic [4:0] num, input logic ov, input logic dn, input logic [3:0] idx);
    chk("num", d, 32'(num), cnt[d]);
    chk("empty", d, 32'(emp), 32'(cnt[d] == 0));
    chk("full", d, 32'(full), 32'(cnt[d] == depth[d]));
    chk("head", d, 32'(arb), cnt[d] > 0 ? 32'(fq[d][0]) : 32'd0);
    chk("overflow", d, 32'(ov), 32'(ovf[d]));
    chk("scan_done", d, 32'(dn), 32'(done[d]));
    chk("idx", d, 32'(idx), pos[d] < nl[d] ? lanes[d][pos[d]] : idle_idx[d]);
  endtask
  task automatic cyc();
    model(0, coll_a, rd_a);
    model(1, coll_s, rd_s);
    @(posedge clk);
    #1;
    chk_dut(0, a_arb, a_emp, a_full, 5'(a_num), a_ovf, a_done, a_idx);
    chk_dut(1, s_arb, s_emp, s_full, s_num, s_ovf, s_done, s_idx);
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((pos[0] < nl[0] || pos[1] < nl[1]) && n < 100) begin
      cyc();
      n++;
    end
    chk("idle_timeout", 0, 32'(n < 100), 1);
  endtask
  initial begin
    int n;
    logic [15:0] exp4 [4];
    for (int k = 0; k < 16; k++) moves[k*16 +: 16] = 16'(k * 16);
    valid = 16'h8005;
    coll_a = 1; coll_s = 1;
    repeat (3) cyc();
    chk("rst_empty", 0, 32'(a_emp), 1);
    chk("rst_arb", 1, 32'(s_arb), 0);
    chk("rst_idx", 0, 32'(a_idx), 0);
    chk("rst_done", 1, 32'(s_done), 0);
    rst = 1;
    cyc();
    chk("post_rst_idx", 0, 32'(a_idx), 0);
    coll_a = 0; coll_s = 0;
    wait_idle();
    rd_a = 1; rd_s = 1;
    repeat (5) cyc();
    rd_a = 0; rd_s = 0;
    tv = '{'{1, 0, 0, 0, 0, 16'h0000}, '{0, 0, 2, 0, 1, 16'h0000}, '{0, 0, 15, 0, 2, 16'h0000},
           '{0, 0, 0, 1, 3, 16'h0000}, '{0, 0, 0, 0, 3, 16'h0000}, '{0, 1, 0, 0, 2, 16'h0020},
           '{0, 1, 0, 0, 1, 16'h00F0}, '{0, 1, 0, 0, 0, 16'h0000}};
    foreach (tv[i]) begin
      coll_s = tv[i].coll;
      rd_s = tv[i].rd;
      cyc();
      chk("tv_idx", 1, 32'(s_idx), 32'(tv[i].idx));
      chk("tv_done", 1, 32'(s_done), 32'(tv[i].done));
      chk("tv_num", 1, 32'(s_num), 32'(tv[i].num));
      chk("tv_head", 1, 32'(s_arb), 32'(tv[i].head));
    end
    coll_s = 0; rd_s = 0;
    coll_a = 1;
    cyc();
    coll_a = 0;
    n = 1;
    while (!a_done && n < 40) begin
      cyc();
      n++;
    end
    chk("all_done_cycles", 0, n, 17);
    cyc();
    exp4 = '{16'h0000, 16'h0020, 16'h00F0, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      chk("all_fifo", 0, 32'(a_arb), 32'(exp4[i]));
      rd_a = 1;
      cyc();
    end
    rd_a = 0;
    chk("all_drained", 0, 32'(a_emp), 1);
    valid = 16'h003F;
    coll_a = 1;
    cyc();
    coll_a = 0;
    wait_idle();
    chk("ovf_full", 0, 32'(a_full), 1);
    chk("ovf_num", 0, 32'(a_num), 4);
    chk("ovf_flag", 0, 32'(a_ovf), 1);
    valid = 16'h0001;
    moves[15:0] = 16'hA000;
    coll_a = 1;
    cyc();
    coll_a = 0;
    chk("rw_head_before", 0, 32'(a_arb), 32'h0000);
    rd_a = 1;
    cyc();
    rd_a = 0;
    chk("rw_num", 0, 32'(a_num), 4);
    chk("rw_ovf", 0, 32'(a_ovf), 0);
    chk("rw_head_after", 0, 32'(a_arb), 32'h0010);
    wait_idle();
    exp4 = '{16'h0010, 16'h0020, 16'h0030, 16'hA000};
    for (int i = 0; i < 4; i++) begin
      chk("rw_fifo", 0, 32'(a_arb), 32'(exp4[i]));
      rd_a = 1;
      cyc();
    end
    rd_a = 0;
    valid = 16'h0000;
    coll_s = 1;
    cyc();
    coll_s = 0;
    chk("skip0_done", 1, 32'(s_done), 1);
    chk("skip0_arb", 1, 32'(s_arb), 0);
    cyc();
    chk("skip0_pulse", 1, 32'(s_done), 0);
    chk("skip0_idx", 1, 32'(s_idx), 0);
    chk("skip0_num", 1, 32'(s_num), 0);
    for (int it = 0; it < 400; it++) begin
      if (pos[1] >= nl[1] && $urandom_range(0, 3) == 0)
        valid = $urandom_range(0, 3) == 0 ? 16'h0000 : 16'($urandom);
      for (int i = 0; i < 8; i++) moves[i*32 +: 32] = $urandom;
      coll_a = $urandom_range(0, 5) == 0;
      coll_s = $urandom_range(0, 4) == 0;
      rd_a = $urandom_range(0, 2) == 0;
      rd_s = $urandom_range(0, 2) == 0;
      if (it == 200) rst = 0;
      if (it == 202) rst = 1;
      cyc();
    end
    coll_a = 0; coll_s = 0; rd_a = 0; rd_s = 0;
    wait_idle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
